// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins; colliding
// MDU writes wait in a small in-order FIFO and drain into idle port cycles.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned RSEL_W     = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              pipe_wen,
    input  logic [RSEL_W-1:0] pipe_wsel,
    input  logic [WORD_W-1:0] pipe_wdat,
    input  logic              mdu_valid,
    input  logic [RSEL_W-1:0] mdu_wsel,
    input  logic [WORD_W-1:0] mdu_wdat,
    output logic              mdu_ready,
    output logic              stall,
    input  logic [RSEL_W-1:0] rsel1,
    input  logic [RSEL_W-1:0] rsel2,
    output logic              hazard,
    output logic              rf_WEN,
    output logic [RSEL_W-1:0] rf_wsel,
    output logic [WORD_W-1:0] rf_wdat
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    logic [RSEL_W-1:0] sel_q [DEPTH];
    logic [WORD_W-1:0] dat_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;

    logic pipe_act;
    logic fifo_empty;
    logic ready_int;
    logic pop;
    logic bypass;
    logic push;
    logic hazard_int;
    logic [PTR_W-1:0] offset;

    // Request decode and grant decisions for this cycle
    always_comb begin
        pipe_act   = pipe_wen && (pipe_wsel != '0);
        fifo_empty = (count_q == '0);
        ready_int  = (count_q < CNT_W'(DEPTH));
        pop        = !pipe_act && !fifo_empty;
        bypass     = !pipe_act && fifo_empty && mdu_valid && (mdu_wsel != '0);
        push       = mdu_valid && ready_int && (mdu_wsel != '0) && !bypass;
    end

    // FIFO pointer/occupancy and starvation counter next state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Control state registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // FIFO storage, written at the tail on push
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sel_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else if (push) begin
            sel_q[wr_ptr_q] <= mdu_wsel;
            dat_q[wr_ptr_q] <= mdu_wdat;
        end
    end

    // Read-after-buffered-write hazard over the occupied entries only
    always_comb begin
        hazard_int = 1'b0;
        offset     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if ((CNT_W'(offset) < count_q) && (sel_q[i] != '0) &&
                ((sel_q[i] == rsel1) || (sel_q[i] == rsel2))) begin
                hazard_int = 1'b1;
            end
        end
    end

    // Write-port mux and status outputs, all held inactive during reset
    always_comb begin
        rf_WEN  = 1'b0;
        rf_wsel = '0;
        rf_wdat = '0;
        if (pipe_act) begin
            rf_WEN  = 1'b1;
            rf_wsel = pipe_wsel;
            rf_wdat = pipe_wdat;
        end else if (!fifo_empty) begin
            rf_WEN  = 1'b1;
            rf_wsel = sel_q[rd_ptr_q];
            rf_wdat = dat_q[rd_ptr_q];
        end else if (bypass) begin
            rf_WEN  = 1'b1;
            rf_wsel = mdu_wsel;
            rf_wdat = mdu_wdat;
        end
        rf_WEN    = rf_WEN && nRST;
        mdu_ready = ready_int && nRST;
        stall     = (starve_q == STV_W'(STARVE_MAX)) && nRST;
        hazard    = hazard_int && nRST;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pipe_wen = 1'b0;
    logic [4:0]  pipe_wsel = '0;
    logic [31:0] pipe_wdat = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_wsel = '0;
    logic [31:0] mdu_wdat = '0;
    logic        mdu_ready;
    logic        stall;
    logic [4:0]  rsel1 = '0;
    logic [4:0]  rsel2 = '0;
    logic        hazard;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;

    regfile_wb_arbiter #(
        .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .WORD_W(32), .RSEL_W(5)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
        .mdu_valid(mdu_valid), .mdu_wsel(mdu_wsel), .mdu_wdat(mdu_wdat),
        .mdu_ready(mdu_ready), .stall(stall),
        .rsel1(rsel1), .rsel2(rsel2), .hazard(hazard),
        .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] dat;
    } wr_t;

    wr_t         fq[$];
    int          starve = 0;
    logic [31:0] m_rf  [32] = '{default: '0};
    logic [31:0] tb_rf [32] = '{default: '0};
    int          nchecks = 0;
    int          nerrors = 0;
    logic        obs_stall = 1'b0;
    logic        obs_ready = 1'b0;

    // Register file fed by the arbiter's write port
    always @(posedge CLK) begin
        if (rf_WEN) tb_rf[rf_wsel] <= rf_wdat;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check outputs against the model, advance the model at the edge
    task automatic cycle(input logic pw, input logic [4:0] ps, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ms, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        bit          pa, e_ready, e_stall, e_haz, byp, e_wen, granted, was_empty;
        logic [4:0]  e_sel;
        logic [31:0] e_dat;
        wr_t         ent;
        pipe_wen = pw; pipe_wsel = ps; pipe_wdat = pd;
        mdu_valid = mdu_valid; mdu_valid = mv; mdu_wsel = ms; mdu_wdat = md;
        rsel1 = r1; rsel2 = r2;
        #2;
        pa        = pw && (ps != 0);
        was_empty = (fq.size() == 0);
        e_ready   = fq.size() < DEPTH;
        e_stall   = (starve == STARVE_MAX);
        e_haz     = 1'b0;
        foreach (fq[k]) if (fq[k].sel == r1 || fq[k].sel == r2) e_haz = 1'b1;
        byp     = !pa && was_empty && mv && (ms != 0);
        granted = !pa && !was_empty;
        e_wen   = pa || granted || byp;
        e_sel   = '0;
        e_dat   = '0;
        if (pa) begin
            e_sel = ps; e_dat = pd;
        end else if (granted) begin
            e_sel = fq[0].sel; e_dat = fq[0].dat;
        end else if (byp) begin
            e_sel = ms; e_dat = md;
        end
        obs_stall = stall;
        obs_ready = mdu_ready;
        chk("rf_wen", 32'(rf_WEN), 32'(e_wen));
        if (e_wen) begin
            chk("rf_wsel", 32'(rf_wsel), 32'(e_sel));
            chk("rf_wdat", rf_wdat, e_dat);
        end
        chk("mdu_ready", 32'(mdu_ready), 32'(e_ready));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("hazard", 32'(hazard), 32'(e_haz));
        @(posedge CLK);
        if (e_wen) m_rf[e_sel] = e_dat;
        if (was_empty || granted) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        if (granted) void'(fq.pop_front());
        if (mv && e_ready && (ms != 0) && !byp) begin
            ent.sel = ms; ent.dat = md;
            fq.push_back(ent);
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] r1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wen"}, 32'(rf_WEN), 32'd0);
        chk({tag, "_ready"}, 32'(mdu_ready), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_hazard"}, 32'(hazard), 32'd0);
    endtask

    initial begin
        logic pw;
        logic mv;
        int   busy_pct;

        // Power-on reset with requests present
        pipe_wen = 1'b1; pipe_wsel = 5'd7; mdu_valid = 1'b1; mdu_wsel = 5'd3;
        #3;
        check_reset_outputs("por");
        @(posedge CLK); #1;
        nRST = 1'b1;
        idle(5'd0);

        // Pipe only, then write to r0 is a free cycle
        cycle(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // MDU bypass on an idle port
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h12, 5'd3, 5'd0);
        idle(5'd3);

        // Collision then drain with hazard visibility
        cycle(1'b1, 5'd5, 32'hA, 1'b1, 5'd9, 32'hB, 5'd9, 5'd0);
        idle(5'd9);
        idle(5'd9);
        chk("readback_r5", tb_rf[5], 32'hA);
        chk("readback_r9", tb_rf[9], 32'hB);

        // Backpressure and in-order drain
        cycle(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'h1, 5'd10, 5'd11);
        cycle(1'b1, 5'd2, 32'h200, 1'b1, 5'd11, 32'h2, 5'd10, 5'd11);
        cycle(1'b1, 5'd4, 32'h400, 1'b1, 5'd12, 32'h3, 5'd10, 5'd11);
        chk("bp_ready_low", 32'(obs_ready), 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h3, 5'd12, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h3, 5'd12, 5'd0);
        idle(5'd12);
        idle(5'd0);
        chk("bp_r10", tb_rf[10], 32'h1);
        chk("bp_r11", tb_rf[11], 32'h2);
        chk("bp_r12", tb_rf[12], 32'h3);

        // Starvation: four denied cycles, stall in the fifth
        cycle(1'b1, 5'd1, 32'h5001, 1'b1, 5'd20, 32'h77, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'(2 + i), 32'h6000 + 32'(i), 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            chk("no_stall_yet", 32'(obs_stall), 32'd0);
        end
        idle(5'd20);
        chk("stall_5th", 32'(obs_stall), 32'd1);
        cycle(1'b1, 5'd6, 32'h7000, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("stall_cleared", 32'(obs_stall), 32'd0);
        chk("starve_r20", tb_rf[20], 32'h77);

        // Reset mid-traffic with two buffered entries
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 5'd2, 5'd4);
        cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 5'd2, 5'd4);
        pipe_wen = 1'b1; pipe_wsel = 5'd6; pipe_wdat = 32'h6;
        mdu_valid = 1'b0; rsel1 = 5'd2; rsel2 = 5'd4;
        #1 nRST = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge CLK); #1;
        check_reset_outputs("midrst_hold");
        nRST = 1'b1;
        fq.delete();
        starve = 0;
        idle(5'd2);

        // Randomized traffic with a well-behaved pipeline honouring stall
        for (int blk = 0; blk < 20; blk++) begin
            busy_pct = int'($urandom_range(20, 95));
            for (int i = 0; i < 25; i++) begin
                pw = ($urandom_range(0, 99) < busy_pct) && (starve != STARVE_MAX);
                mv = ($urandom_range(0, 99) < 60);
                cycle(pw, 5'($urandom_range(0, 15)), $urandom,
                      mv, 5'($urandom_range(0, 15)), $urandom,
                      5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(5'd0);
        chk("drained", 32'(fq.size()), 32'd0);
        for (int r = 1; r < 32; r++) chk($sformatf("rf_r%0d", r), tb_rf[r], m_rf[r]);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WEN/wsel/wdat of register_file_if) between two writers: the pipeline writeback stage (primary) and the multicycle multiply/divide unit (MDU, secondary).
- The pipeline always wins. Colliding MDU writes are held in a small FIFO and drained into idle write-port cycles.
- A starvation counter forces a one-cycle pipeline stall so that buffered writes cannot be delayed indefinitely.
- Decode gets a hazard flag for reads that target a register with a buffered, not-yet-written value.

Parameters:
- DEPTH, 2, MDU buffer entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive denied cycles before stall is asserted
- WORD_W, 32, data width (word_t)
- RSEL_W, 5, register select width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- pipe_wen  in  1  pipeline write request
- pipe_wsel  in  RSEL_W  pipeline destination register
- pipe_wdat  in  WORD_W  pipeline write data
- mdu_valid  in  1  MDU write offered
- mdu_wsel  in  RSEL_W  MDU destination register
- mdu_wdat  in  WORD_W  MDU write data
- mdu_ready  out  1  MDU write accepted this cycle when high with mdu_valid
- stall  out  1  pipeline must hold writeback (pipe_wen=0) this cycle
- rsel1, rsel2  in  RSEL_W  decode read selects
- hazard  out  1  rsel1/rsel2 matches a buffered MDU destination
- rf_WEN  out  1  to register_file_if WEN
- rf_wsel  out  RSEL_W  to register_file_if wsel
- rf_wdat  out  WORD_W  to register_file_if wdat

Behaviour:
- Reset (nRST low, async): FIFO empty (count=0, pointers=0), starve_cnt=0. While nRST=0, force rf_WEN=0, mdu_ready=0, stall=0, hazard=0. rf_wsel/rf_wdat are don't-care.
- Effective pipe request: pipe_act = pipe_wen && pipe_wsel!=0. A write to register 0 is a free port cycle.
- Write-port mux is combinational, zero latency; the register file captures on the same edge. Priority:
  1. pipe_act: the pipeline write goes out.
  2. Else, FIFO non-empty: the FIFO head goes out and is popped at the edge.
  3. Else, mdu_valid && mdu_wsel!=0: bypass, the MDU data goes out and nothing is stored.
  4. Else rf_WEN=0.
- mdu_ready = (count < DEPTH). It depends only on registered state, not on mdu_valid.
- MDU accept (mdu_valid && mdu_ready) routing:
  - wsel==0: discarded.
  - Bypassed per rule 3: not stored.
  - Otherwise: pushed at the tail.
- Push and pop in the same cycle is legal: count is unchanged, and the head pop precedes the tail push in order.
- FIFO order is strict; MDU writes retire in acceptance order.
- Pointers wrap modulo DEPTH. count is 0..DEPTH; overflow and underflow must be impossible by construction.
- starve_cnt (saturating at STARVE_MAX):
  - Clear to 0 when the FIFO is empty or the head is granted.
  - Otherwise, while the FIFO is non-empty and the head is denied, increment.
- stall = (starve_cnt == STARVE_MAX), decoded from the flop only.
- Stall protocol: while stall=1 the pipeline drives pipe_wen=0, so the head is granted and the counter clears.
  - If pipe_wen=1 during stall, the pipeline still wins; the bench flags this as a protocol violation.
- hazard = OR over valid FIFO entries of (entry.wsel==rsel1 || entry.wsel==rsel2). Combinational. Register 0 never hazards.
- Same-destination collision: the pipe and the buffered head target the same register. The pipe writes first and the head writes later. The resulting program-order issue is decode's responsibility via hazard; no merge is performed.

Test Plan:
- Reset mid-traffic: FIFO holding 2 entries, pulse nRST low → rf_WEN=0 immediately, count=0, mdu_ready=1 after release, stall=0, hazard=0.
- Pipe only: pipe_wen=1, wsel=7, wdat=0xDEADBEEF → same cycle rf_WEN=1, rf_wsel=7, rf_wdat=0xDEADBEEF. Then wsel=0 → rf_WEN=0.
- MDU bypass: idle pipe, mdu_valid=1, wsel=3, wdat=0x12 → rf_* carries it the same cycle, mdu_ready=1, count stays 0.
- Collision and drain: pipe (r5,0xA) and MDU (r9,0xB) in the same cycle → r5 written, r9 buffered, hazard=1 for rsel1=9. Next idle cycle: r9=0xB written, hazard=0. A register_file readback confirms r5=0xA, r9=0xB.
- Backpressure: pipe busy every cycle, MDU offering every cycle → mdu_ready=0 after 2 accepts. FIFO order is preserved on drain (values 0x1 then 0x2 to r10, r11).
- Starvation: FIFO non-empty, pipe writes continuously → stall=1 in the 5th cycle after first denial. With pipe_wen=0 the head is written, stall drops the next cycle, starve_cnt=0.
